// File: rtl/slink_apb_pkg.sv
// slink_apb_pkg: FSM states, default data IDs and payload layout shared by the S-Link APB bridge
package slink_apb_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
  localparam logic [7:0] DT_APB_READ      = 8'h30;
  localparam logic [7:0] DT_APB_READ_RSP  = 8'h31;
  localparam logic [7:0] DT_APB_WRITE     = 8'h32;
  localparam logic [7:0] DT_APB_WRITE_RSP = 8'h33;
  localparam int ADDR_LSB   = 0;
  localparam int WDATA_LSB  = 32;
  localparam int RDATA_LSB  = 0;
  localparam int RD_ERR_BIT = 32;
  localparam int WR_ERR_BIT = 0;
  localparam logic [15:0] WR_WC = 16'd8;
  localparam logic [15:0] RD_WC = 16'd4;
endpackage

// File: rtl/slink_apb_tgt_bridge.sv
// slink_apb_tgt_bridge: APB target that tunnels each access as an S-Link request/response packet pair
module slink_apb_tgt_bridge
  import slink_apb_pkg::*;
#(
  parameter int TX_APP_DATA_WIDTH = 128,
  parameter int RX_APP_DATA_WIDTH = 128,
  parameter logic [7:0] APB_WRITE_DT = DT_APB_WRITE,
  parameter logic [7:0] APB_READ_DT = DT_APB_READ,
  parameter logic [7:0] APB_WRITE_RSP_DT = DT_APB_WRITE_RSP,
  parameter logic [7:0] APB_READ_RSP_DT = DT_APB_READ_RSP,
  parameter int RSP_TIMEOUT = 1024
) (
  input  logic                         apb_clk,
  input  logic                         apb_reset,
  input  logic [31:0]                  apb_paddr,
  input  logic                         apb_pwrite,
  input  logic                         apb_psel,
  input  logic                         apb_penable,
  input  logic [31:0]                  apb_pwdata,
  output logic [31:0]                  apb_prdata,
  output logic                         apb_pready,
  output logic                         apb_pslverr,
  input  logic                         enable,
  output logic                         tx_sop,
  output logic [7:0]                   tx_data_id,
  output logic [15:0]                  tx_word_count,
  output logic [TX_APP_DATA_WIDTH-1:0] tx_app_data,
  input  logic                         tx_advance,
  input  logic                         rx_sop,
  input  logic [7:0]                   rx_data_id,
  input  logic [15:0]                  rx_word_count,
  input  logic [RX_APP_DATA_WIDTH-1:0] rx_app_data,
  input  logic                         rx_valid,
  input  logic                         rx_crc_corrupted
);
  localparam int TW = $clog2(RSP_TIMEOUT + 1);
  state_t state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_nxt;
  logic wr_q, err_q, err_nxt, rsp_hit, tmo;
  logic [TW-1:0] tcnt;
  logic unused_rx;
  assign unused_rx = ^{rx_word_count, rx_app_data};
  assign rsp_hit = rx_sop & rx_valid & (rx_data_id == (wr_q ? APB_WRITE_RSP_DT : APB_READ_RSP_DT));
  assign tmo = tcnt == TW'(RSP_TIMEOUT - 1);
  always_comb begin
    state_nxt = state;
    rdata_nxt = rdata_q;
    err_nxt = err_q;
    case (state)
      IDLE: if (apb_psel) begin
        state_nxt = enable ? SEND : DONE;
        rdata_nxt = '0;
        err_nxt = !enable;
      end
      SEND: if (tx_advance) state_nxt = WAIT_RSP;
      WAIT_RSP: if (rsp_hit) begin
        state_nxt = DONE;
        rdata_nxt = (rx_crc_corrupted | wr_q) ? '0 : rx_app_data[RDATA_LSB +: 32];
        err_nxt = rx_crc_corrupted | (wr_q ? rx_app_data[WR_ERR_BIT] : rx_app_data[RD_ERR_BIT]);
      end else if (tmo) begin
        state_nxt = DONE;
        rdata_nxt = '0;
        err_nxt = 1'b1;
      end
      DONE: if (apb_psel & apb_penable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge apb_clk or posedge apb_reset) begin
    if (apb_reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      tcnt <= '0;
    end else begin
      state <= state_nxt;
      rdata_q <= rdata_nxt;
      err_q <= err_nxt;
      tcnt <= state == SEND ? '0 : state == WAIT_RSP ? tcnt + 1'b1 : tcnt;
      if (state == IDLE && apb_psel && enable) begin
        addr_q <= apb_paddr;
        wdata_q <= apb_pwdata;
        wr_q <= apb_pwrite;
      end
    end
  end
  assign tx_sop = state == SEND;
  assign tx_data_id = tx_sop ? (wr_q ? APB_WRITE_DT : APB_READ_DT) : '0;
  assign tx_word_count = tx_sop ? (wr_q ? WR_WC : RD_WC) : '0;
  always_comb begin
    tx_app_data = '0;
    if (tx_sop) begin
      tx_app_data[ADDR_LSB +: 32] = addr_q;
      if (wr_q) tx_app_data[WDATA_LSB +: 32] = wdata_q;
    end
  end
  // Response fields are only visible during the completing cycle
  assign apb_pready = (state == DONE) & apb_psel & apb_penable;
  assign apb_prdata = apb_pready ? rdata_q : '0;
  assign apb_pslverr = apb_pready & err_q;
endmodule

// File: tb/tb_slink_apb_tgt_bridge.sv
// tb_slink_apb_tgt_bridge: scoreboard bench for the S-Link APB target bridge
module tb_slink_apb_tgt_bridge;
  localparam int TOUT = 1024;
  logic clk = 0, apb_reset = 1;
  logic [31:0] apb_paddr = 0, apb_pwdata = 0, apb_prdata;
  logic apb_pwrite = 0, apb_psel = 0, apb_penable = 0, apb_pready, apb_pslverr;
  logic enable = 1, tx_sop, tx_advance = 0;
  logic [7:0] tx_data_id, rx_data_id = 0;
  logic [15:0] tx_word_count, rx_word_count = 0;
  logic [127:0] tx_app_data, rx_app_data = 0;
  logic rx_sop = 0, rx_valid = 0, rx_crc_corrupted = 0;
  typedef struct packed { logic [7:0] id; logic [15:0] wc; logic [127:0] data; } txe_t;
  typedef struct packed { logic [31:0] rdata; logic err; } rspe_t;
  txe_t tx_q[$];
  rspe_t rsp_q[$];
  int total = 0, bad = 0, sop_cycles = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (tx_sop) sop_cycles++;
  slink_apb_tgt_bridge #(.RSP_TIMEOUT(TOUT)) dut (
    .apb_clk(clk), .apb_reset(apb_reset), .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwdata(apb_pwdata),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
    .enable(enable), .tx_sop(tx_sop), .tx_data_id(tx_data_id), .tx_word_count(tx_word_count),
    .tx_app_data(tx_app_data), .tx_advance(tx_advance), .rx_sop(rx_sop), .rx_data_id(rx_data_id),
    .rx_word_count(rx_word_count), .rx_app_data(rx_app_data), .rx_valid(rx_valid),
    .rx_crc_corrupted(rx_crc_corrupted));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pready"}, apb_pready, 0);
    chk({tag, "_prdata"}, apb_prdata, 0);
    chk({tag, "_pslverr"}, apb_pslverr, 0);
    chk({tag, "_tx"}, {tx_sop, tx_data_id, tx_word_count, tx_app_data}, 0);
  endtask
  task automatic apb_start(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(negedge clk);
    apb_paddr = a; apb_pwrite = w; apb_pwdata = d; apb_psel = 1; apb_penable = 0;
    @(negedge clk);
    apb_penable = 1;
    #1;
  endtask
  task automatic do_tx(input int adv_dly);
    txe_t e;
    int n = 0;
    while (!tx_sop && n < 20) begin @(negedge clk); #1; n++; end
    chk("tx_sop", tx_sop, 1);
    if (tx_q.size() == 0) begin chk("tx_q_empty", 1, 0); return; end
    e = tx_q.pop_front();
    for (int i = 0; i <= adv_dly; i++) begin
      chk("tx_data_id", tx_data_id, e.id);
      chk("tx_word_count", tx_word_count, e.wc);
      chk("tx_app_data", tx_app_data, e.data);
      if (i == adv_dly) tx_advance = 1;
      @(negedge clk);
      #1;
    end
    tx_advance = 0;
    chk("tx_sop_drop", tx_sop, 0);
  endtask
  task automatic send_rsp(input logic sop, input logic [7:0] id, input logic [127:0] d, input logic crc);
    rx_sop = sop; rx_valid = 1; rx_data_id = id; rx_app_data = d; rx_crc_corrupted = crc;
    rx_word_count = 16'd4;
    @(negedge clk);
    rx_sop = 0; rx_valid = 0; rx_data_id = 0; rx_app_data = 0; rx_crc_corrupted = 0;
    #1;
  endtask
  task automatic wait_done(input int limit, output int n);
    rspe_t e;
    n = 0;
    while (!apb_pready && n < limit) begin @(negedge clk); #1; n++; end
    chk("pready", apb_pready, 1);
    if (rsp_q.size() == 0) chk("rsp_q_empty", 1, 0);
    else begin
      e = rsp_q.pop_front();
      chk("prdata", apb_prdata, e.rdata);
      chk("pslverr", apb_pslverr, e.err);
    end
    @(negedge clk);
    #1;
    chk("pready_pulse", apb_pready, 0);
    chk("prdata_after", apb_prdata, 0);
    apb_psel = 0; apb_penable = 0;
  endtask
  initial begin
    int n, s0;
    #1;
    chk_idle_outputs("reset");
    @(negedge clk); apb_reset = 0;
    tx_q.push_back('{8'h32, 16'd8, 128'h4552abef_12345678});
    rsp_q.push_back('{32'h0, 1'b0});
    apb_start(32'h1234_5678, 1, 32'h4552_abef);
    do_tx(3);
    send_rsp(1, 8'h33, 128'hffff_0000_0000_0000_0000_0000_0000_fffe, 0);
    wait_done(50, n);
    tx_q.push_back('{8'h32, 16'd8, 128'h0000_0001_a000_0004});
    rsp_q.push_back('{32'h0, 1'b1});
    apb_start(32'ha000_0004, 1, 32'h1);
    do_tx(0);
    send_rsp(1, 8'h33, 128'h1, 0);
    wait_done(50, n);
    tx_q.push_back('{8'h30, 16'd4, 128'hbabacdcd});
    rsp_q.push_back('{32'hdeadbeef, 1'b0});
    apb_start(32'hbaba_cdcd, 0, 32'h7777_7777);
    do_tx(1);
    send_rsp(1, 8'h31, 128'h0000_abcd_0000_0000_0000_0000_deadbeef, 0);
    wait_done(50, n);
    tx_q.push_back('{8'h30, 16'd4, 128'h0000_0100});
    rsp_q.push_back('{32'h0, 1'b1});
    apb_start(32'h0000_0100, 0, 32'h0);
    do_tx(0);
    send_rsp(1, 8'h31, 128'h1111, 1);
    wait_done(50, n);
    tx_q.push_back('{8'h30, 16'd4, 128'h0000_0200});
    rsp_q.push_back('{32'hcafef00d, 1'b1});
    apb_start(32'h0000_0200, 0, 32'h0);
    do_tx(0);
    send_rsp(1, 8'h33, 128'h5555, 0);
    send_rsp(0, 8'h31, 128'h6666, 0);
    chk("wrong_id_ignored", apb_pready, 0);
    @(negedge clk); #1;
    chk("wrong_id_ignored2", apb_pready, 0);
    send_rsp(1, 8'h31, 128'h1_cafef00d, 0);
    wait_done(50, n);
    tx_q.push_back('{8'h30, 16'd4, 128'h0000_0300});
    rsp_q.push_back('{32'h0, 1'b1});
    apb_start(32'h0000_0300, 0, 32'h0);
    do_tx(0);
    wait_done(2 * TOUT, n);
    chk("timeout_cycles", n, TOUT);
    enable = 0;
    s0 = sop_cycles;
    rsp_q.push_back('{32'h0, 1'b1});
    apb_start(32'h0000_0400, 1, 32'hffff_ffff);
    wait_done(50, n);
    repeat (2) @(negedge clk);
    chk("disabled_no_sop", sop_cycles, s0);
    enable = 1;
    tx_q.push_back('{8'h30, 16'd4, 128'h0000_0500});
    apb_start(32'h0000_0500, 0, 32'h0);
    do_tx(0);
    apb_reset = 1;
    #1;
    chk_idle_outputs("abort");
    @(negedge clk);
    apb_psel = 0; apb_penable = 0; apb_reset = 0;
    #1;
    send_rsp(1, 8'h31, 128'h1234, 0);
    chk("stale_rsp_pready", apb_pready, 0);
    chk("stale_rsp_sop", tx_sop, 0);
    tx_q.push_back('{8'h32, 16'd8, 128'h89ab_cdef_0000_0600});
    rsp_q.push_back('{32'h0, 1'b0});
    apb_start(32'h0000_0600, 1, 32'h89ab_cdef);
    do_tx(2);
    send_rsp(1, 8'h33, 128'h0, 0);
    wait_done(50, n);
    chk("tx_q_drained", tx_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/slink_apb_tgt_bridge.md
Name: slink_apb_tgt_bridge

Overview:
APB target that tunnels each APB access over an S-Link packet interface. A write becomes an APB_WRITE_DT packet; a read becomes an APB_READ_DT packet. The APB access is stalled (pready low) until the matching response packet returns from the remote initiator, or until a timeout expires. The block sits between the application APB fabric and the S-Link TX/RX application ports on the master side of the link.

Parameters:
TX_APP_DATA_WIDTH, 128, TX payload width in bits; must be >=64.
RX_APP_DATA_WIDTH, 128, RX payload width in bits; must be >=33.
APB_WRITE_DT, 8'h32, data ID of an outgoing write request.
APB_READ_DT, 8'h30, data ID of an outgoing read request.
APB_WRITE_RSP_DT, 8'h33, data ID of an incoming write response.
APB_READ_RSP_DT, 8'h31, data ID of an incoming read response.
RSP_TIMEOUT, 1024, cycles allowed in WAIT_RSP before the access is force-completed with an error.

Ports:
apb_clk  in  1  single clock for the APB and link sides; any CDC is handled outside this block.
apb_reset  in  1  asynchronous, active-high reset.
apb_paddr  in  32  APB address.
apb_pwrite  in  1  1=write, 0=read.
apb_psel  in  1  APB select.
apb_penable  in  1  APB enable (access phase).
apb_pwdata  in  32  write data.
apb_prdata  out  32  read data; valid while pready=1.
apb_pready  out  1  transfer complete.
apb_pslverr  out  1  error flag; valid while pready=1.
enable  in  1  bridge enable.
tx_sop  out  1  TX packet request.
tx_data_id  out  8  TX data ID.
tx_word_count  out  16  TX payload byte count.
tx_app_data  out  TX_APP_DATA_WIDTH  TX payload.
tx_advance  in  1  TX beat accepted.
rx_sop  in  1  RX start of packet.
rx_data_id  in  8  RX data ID.
rx_word_count  in  16  RX payload byte count.
rx_app_data  in  RX_APP_DATA_WIDTH  RX payload.
rx_valid  in  1  RX beat valid.
rx_crc_corrupted  in  1  RX packet CRC error.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0. Reset asserted mid-transaction aborts it immediately; no response is given to the aborted access.
- States: IDLE, SEND, WAIT_RSP, DONE.
- IDLE, psel=1, enable=1: latch paddr, pwdata and pwrite; go to SEND the next cycle.
- IDLE, psel=1, enable=0: go to DONE with prdata=0 and pslverr=1; no packet is sent.
- SEND:
  - tx_sop=1.
  - Write: tx_data_id=APB_WRITE_DT, tx_word_count=8, tx_app_data[31:0]=addr, [63:32]=wdata.
  - Read: tx_data_id=APB_READ_DT, tx_word_count=4, tx_app_data[31:0]=addr.
  - Unused tx_app_data bits are 0.
  - All TX outputs are held stable until a cycle with tx_advance=1. The packet is a single beat; the next cycle tx_sop=0 and the FSM goes to WAIT_RSP.
- WAIT_RSP: accept a beat with rx_sop & rx_valid whose rx_data_id is the expected response (write->APB_WRITE_RSP_DT, read->APB_READ_RSP_DT).
  - Write response: pslverr=rx_app_data[0].
  - Read response: prdata=rx_app_data[31:0], pslverr=rx_app_data[32].
  - rx_crc_corrupted=1 on the accepted beat: prdata=0, pslverr=1.
  - On acceptance go to DONE.
  - Any other data ID, or a beat without rx_sop, is ignored.
  - rx_word_count is not checked.
- Timeout counter: cleared on entering WAIT_RSP, incremented each cycle in WAIT_RSP. When it reaches RSP_TIMEOUT: DONE with prdata=0, pslverr=1.
- DONE:
  - pready=1 for exactly one cycle, while psel & penable are high.
  - prdata/pslverr are valid only in that cycle and are 0 otherwise.
  - Return to IDLE.
  - If the master has not yet raised penable, hold DONE until psel & penable.
- RX beats arriving outside WAIT_RSP are discarded.
- Only one outstanding transaction; APB back-pressure prevents overlap.
- Write latency from setup to pready: 1 + (cycles to tx_advance) + (response wait) + 1.

Decomposition:
- Shared package slink_apb_pkg holds:
  - FSM state enum.
  - Default data IDs 0x30–0x33.
  - Payload field offsets: ADDR=[31:0], WDATA=[63:32], RDATA=[31:0], ERR bit 32 for read, ERR bit 0 for write.
  - Request word counts 8 and 4.
- Single module; no sub-module needed. The payload pack/unpack is combinational inside.

Test Plan:
1. Write with tx_advance 3 cycles after tx_sop, then response id 0x33 with data[0]=0.
   - paddr=0x1234_5678, pwdata=0x4552_abef.
   - Required TX: tx_data_id=0x32, wc=8, tx_app_data[63:0]=0x4552abef_12345678; outputs stable while waiting.
   - Required APB: pready pulse, pslverr=0.
2. Read paddr=0xbaba_cdcd; response id 0x31 with data[32:0]={0,0xdeadbeef}.
   - Required TX: id 0x30, wc=4, data[31:0]=0xbabacdcd.
   - Required APB: prdata=0xdeadbeef, pslverr=0.
3. Read with response rx_crc_corrupted=1 -> prdata=0, pslverr=1.
4. Response with wrong ID (0x33 during a read), then the correct 0x31 -> first ignored, second completes. Separately, a read with no response -> pslverr=1 after exactly RSP_TIMEOUT cycles.
5. enable=0 with a write -> no tx_sop, pready=1 with pslverr=1 on the access phase.
6. apb_reset asserted in WAIT_RSP -> all outputs 0 immediately. A subsequent write completes normally, and a stale response arriving in IDLE is ignored.
